ex_sequencer: RTL

Control sequencer for the execute stage. Accepts decoded ALUOp/funct/branch/ALUSrc controls from the decode stage and drives ALU control, operand select, and capture enables into the EX datapath. Stretches MUL over a configurable number of cycles and stalls decode meanwhile. Resolves BEQ from the ALU `zero` flag and issues a one-cycle taken/flush pulse.

---
 rtl/ex_sequencer_if.sv | 34 +++
 rtl/ex_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_sequencer_if.sv
// Decode/EX handshake and control bundle for ex_sequencer.
// master = decode side plus the EX zero flag, slave = the sequencer.
interface ex_sequencer_if;
   logic       id_valid;
   logic [1:0] id_aluop;
   logic [5:0] id_funct;
   logic       id_branch;
   logic       id_alusrc;
   logic       zero;
   logic       ex_ready;
   logic [3:0] alu_control;
   logic       alu_src;
   logic       alu_en;
   logic       result_valid;
   logic       branch_taken;
   logic       flush;
   logic       illegal;

   modport master (
      output id_valid, id_aluop, id_funct,
      output id_branch, id_alusrc, zero,
      input  ex_ready, alu_control, alu_src,
      input  alu_en, result_valid,
      input  branch_taken, flush, illegal
   );

   modport slave (
      input  id_valid, id_aluop, id_funct,
      input  id_branch, id_alusrc, zero,
      output ex_ready, alu_control, alu_src,
      output alu_en, result_valid,
      output branch_taken, flush, illegal
   );
endinterface

// File: rtl/ex_sequencer.sv
// Execute-stage control sequencer: ALU control, multi-cycle MUL, BEQ resolve.
// Define EX_SEQ_FAST_MUL_EN to treat MUL as single-cycle (no MUL state/counter).
module ex_sequencer #(
   parameter int MUL_CYCLES = 4
) (
   input logic           clk,
   input logic           reset,
   ex_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      BR   = 2'd3
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;

   localparam logic [5:0] FN_ADD = 6'b000000;
   localparam logic [5:0] FN_SUB = 6'b000001;
   localparam logic [5:0] FN_MUL = 6'b000010;

`ifdef EX_SEQ_FAST_MUL_EN
   localparam bit MUL_1C = 1'b1;
`else
   localparam bit MUL_1C = (MUL_CYCLES == 1);
`endif

   state_e     state_q, state_d;
   logic [3:0] ctrl_q, ctrl_d;
   logic       src_q, src_d;
   logic       en_q, en_d;
   logic       rv_q, rv_d;
   logic       taken_q, taken_d;
   logic       il_q, il_d;

   logic       ready;
   logic       accept;
   logic       mul_busy;
   logic       mul_last;
   logic       mul_done;

   state_e     dec_state;
   logic [3:0] dec_ctrl;
   logic       dec_en;
   logic       dec_rv;
   logic       dec_il;

`ifdef EX_SEQ_FAST_MUL_EN
   assign mul_busy = 1'b0;
   assign mul_last = 1'b0;
   assign mul_done = 1'b0;
`else
   localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

   logic [3:0] cnt_q, cnt_d;

   assign mul_busy = (state_q == MUL) && (cnt_q != 4'd0);
   assign mul_last = (state_q == MUL) && (cnt_q == 4'd1);
   assign mul_done = (state_q == MUL) && (cnt_q == 4'd0);

   always_comb begin
      cnt_d = cnt_q;
      if (mul_busy) begin
         cnt_d = cnt_q - 4'd1;
      end else if (accept && dec_state == MUL) begin
         cnt_d = CNT_INIT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign ready = (state_q == IDLE) || (state_q == EXEC) || mul_done;
   // A taken branch squashes whatever decode offers in the flush cycle.
   assign accept = bus.id_valid && ready && !taken_q;

   always_comb begin
      dec_state = EXEC;
      dec_ctrl  = ALU_ADD;
      dec_en    = 1'b1;
      dec_rv    = 1'b1;
      dec_il    = 1'b0;
      if (bus.id_aluop == 2'b01 || bus.id_branch) begin
         dec_state = BR;
         dec_ctrl  = ALU_SUB;
         dec_rv    = 1'b0;
      end else if (bus.id_aluop == 2'b00) begin
         dec_ctrl = ALU_ADD;
      end else if (bus.id_aluop == 2'b10 && bus.id_funct == FN_ADD) begin
         dec_ctrl = ALU_ADD;
      end else if (bus.id_aluop == 2'b10 && bus.id_funct == FN_SUB) begin
         dec_ctrl = ALU_SUB;
      end else if (bus.id_aluop == 2'b10 && bus.id_funct == FN_MUL) begin
         dec_ctrl = ALU_MUL;
         if (!MUL_1C) begin
            dec_state = MUL;
            dec_rv    = 1'b0;
         end
      end else begin
         dec_en = 1'b0;
         dec_rv = 1'b0;
         dec_il = 1'b1;
      end
   end

   always_comb begin
      state_d = IDLE;
      unique case (state_q)
         BR:      state_d = IDLE;
         MUL:     state_d = mul_busy ? MUL : (accept ? dec_state : IDLE);
         default: state_d = accept ? dec_state : IDLE;
      endcase
   end

   always_comb begin
      ctrl_d  = ALU_ADD;
      src_d   = 1'b0;
      en_d    = 1'b0;
      rv_d    = 1'b0;
      taken_d = 1'b0;
      il_d    = 1'b0;
      if (state_q == BR) begin
         taken_d = bus.zero;
      end else if (mul_busy) begin
         ctrl_d = ALU_MUL;
         src_d  = src_q;
         en_d   = 1'b1;
         rv_d   = mul_last;
      end else if (accept) begin
         ctrl_d = dec_ctrl;
         src_d  = bus.id_alusrc;
         en_d   = dec_en;
         rv_d   = dec_rv;
         il_d   = dec_il;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ctrl_q  <= ALU_ADD;
         src_q   <= 1'b0;
         en_q    <= 1'b0;
         rv_q    <= 1'b0;
         taken_q <= 1'b0;
         il_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         src_q   <= src_d;
         en_q    <= en_d;
         rv_q    <= rv_d;
         taken_q <= taken_d;
         il_q    <= il_d;
      end
   end

   assign bus.ex_ready     = ready;
   assign bus.alu_control  = ctrl_q;
   assign bus.alu_src      = src_q;
   assign bus.alu_en       = en_q;
   assign bus.result_valid = rv_q;
   assign bus.branch_taken = taken_q;
   assign bus.flush        = taken_q;
   assign bus.illegal      = il_q;

endmodule
